// File: rtl/bp_be_irf_dbg_access.sv
// Debug access port to the integer register file: one read or write per request.
// Optional macro BP_BE_IRF_DBG_X0_GUARD_EN refuses debug writes to register 0.
module bp_be_irf_dbg_access #(
    parameter int dword_width_p    = 64,
    parameter int reg_addr_width_p = 5
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        halted_i,
    input  logic                        req_v_i,
    output logic                        req_ready_o,
    input  logic                        req_w_i,
    input  logic [reg_addr_width_p-1:0] req_addr_i,
    input  logic [dword_width_p-1:0]    req_data_i,
    output logic                        resp_v_o,
    input  logic                        resp_ready_i,
    output logic [dword_width_p-1:0]    resp_data_o,
    output logic                        resp_err_o,
    output logic                        irf_r_v_o,
    output logic                        irf_w_v_o,
    output logic [reg_addr_width_p-1:0] irf_addr_o,
    output logic [dword_width_p-1:0]    irf_data_o,
    input  logic [dword_width_p-1:0]    irf_data_i
);

`ifdef BP_BE_IRF_DBG_X0_GUARD_EN
    localparam logic X0_GUARD = 1'b1;
`else
    localparam logic X0_GUARD = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        CAPTURE,
        RESP
    } state_e;

    state_e                      state_q, state_d;
    logic                        ready_q, ready_d;
    logic                        w_q, w_d;
    logic [reg_addr_width_p-1:0] addr_q, addr_d;
    logic [dword_width_p-1:0]    data_q, data_d;
    logic [dword_width_p-1:0]    resp_data_q, resp_data_d;
    logic                        resp_err_q, resp_err_d;

    logic accept;
    logic x0_hit;
    logic refuse;

    assign accept = req_v_i & ready_q;
    assign x0_hit = X0_GUARD & req_w_i & (req_addr_i == '0);
    assign refuse = ~halted_i | x0_hit;

    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        addr_d      = addr_q;
        data_d      = data_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    w_d         = req_w_i;
                    addr_d      = req_addr_i;
                    data_d      = req_data_i;
                    resp_data_d = '0;
                    resp_err_d  = refuse;
                    state_d     = refuse ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                state_d = w_q ? RESP : CAPTURE;
            end
            CAPTURE: begin
                resp_data_d = irf_data_i;
                state_d     = RESP;
            end
            RESP: begin
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Registered ready: low in reset and in the handshake cycle.
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            w_q         <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            w_q         <= w_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    assign req_ready_o = ready_q;
    assign resp_v_o    = (state_q == RESP);
    assign resp_data_o = resp_data_q;
    assign resp_err_o  = resp_err_q;
    assign irf_r_v_o   = (state_q == ACCESS) & ~w_q;
    assign irf_w_v_o   = (state_q == ACCESS) & w_q;
    assign irf_addr_o  = addr_q;
    assign irf_data_o  = data_q;

endmodule

// File: doc/bp_be_irf_dbg_access.md
BP_BE_IRF_DBG_ACCESS -- requirements
Module: bp_be_irf_dbg_access

Interface
REQ-001 SHALL have parameter dword_width_p, default 64, meaning register data width.
REQ-002 SHALL have parameter reg_addr_width_p, default 5, meaning integer register address width.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n_i, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port halted_i, input, 1, core pipeline quiesced.
REQ-006 SHALL have ports req_v_i (input, 1) and req_ready_o (output, 1), debug request valid/ready.
REQ-007 SHALL have ports req_w_i (input, 1), req_addr_i (input, reg_addr_width_p) and req_data_i (input, dword_width_p): 1=write/0=read, register index, write data.
REQ-008 SHALL have ports resp_v_o (output, 1) and resp_ready_i (input, 1), response valid/ready.
REQ-009 SHALL have ports resp_data_o (output, dword_width_p), read data (0 for writes and errors), and resp_err_o (output, 1), request refused.
REQ-010 SHALL have ports irf_r_v_o and irf_w_v_o (output, 1 each), regfile cfg read and write strobes.
REQ-011 SHALL have ports irf_addr_o (output, reg_addr_width_p) and irf_data_o (output, dword_width_p), regfile cfg address and write data.
REQ-012 SHALL have port irf_data_i, input, dword_width_p, regfile cfg read data, valid the cycle after irf_r_v_o.

Function
REQ-013 SHALL implement FSM states IDLE, ACCESS, CAPTURE, RESP.
REQ-014 SHALL drive req_ready_o=1 only in IDLE; a request is accepted when req_v_i & req_ready_o.
REQ-015 SHALL register req_w_i, req_addr_i and req_data_i on acceptance; irf_addr_o and irf_data_o SHALL come only from these registers.
REQ-016 SHALL, on acceptance with halted_i=0, go to RESP with resp_err_o=1 and resp_data_o=0, and SHALL assert no strobe.
REQ-017 SHALL, on acceptance with halted_i=1, go to ACCESS.
REQ-018 SHALL, in ACCESS, assert exactly one of irf_r_v_o/irf_w_v_o for exactly one cycle, selected by the registered req_w.
REQ-019 SHALL go from ACCESS to RESP for a write and to CAPTURE for a read.
REQ-020 SHALL, in CAPTURE, latch irf_data_i into the response data register, then go to RESP.
REQ-021 SHALL hold resp_v_o=1 in RESP with stable resp_data_o/resp_err_o until resp_ready_i=1, then go to IDLE.
REQ-022 SHALL meet these latencies, accept at cycle N: read resp_v_o at N+3; write at N+2; refused at N+1.
REQ-023 SHALL complete an operation already in ACCESS or CAPTURE even if halted_i deasserts.
REQ-024 SHALL NOT accept a new request in the cycle a response is consumed; the next acceptance is one cycle later at earliest.
REQ-025 SHALL keep irf_r_v_o and irf_w_v_o mutually exclusive in all states.

Reset
REQ-026 SHALL, while reset_n_i=0, force state IDLE and registers to 0, giving resp_v_o=0, resp_err_o=0, resp_data_o=0, irf_r_v_o=0, irf_w_v_o=0, irf_addr_o=0, irf_data_o=0 and req_ready_o=0.
REQ-027 SHALL abandon any operation in progress on reset assertion with no response, and SHALL raise req_ready_o the first clock after deassertion.

Configuration
REQ-028 SHALL provide macro BP_BE_IRF_DBG_X0_GUARD_EN.
REQ-029 SHALL, with the macro defined, complete a write to address 0 as a refusal: no irf_w_v_o, resp_err_o=1 at N+1.
REQ-030 SHALL, with the macro undefined, handle a write to address 0 like any other write.

Verification
REQ-031 Halted, write addr 5 data 0xDEAD_BEEF -> irf_w_v_o one cycle at N+1 with addr 5 and data 0xDEAD_BEEF; resp_v_o at N+2, err=0, data=0.
REQ-032 Halted, read addr 5, irf_data_i=0xDEAD_BEEF at N+2 -> irf_r_v_o one cycle at N+1; resp_v_o at N+3, data 0xDEAD_BEEF.
REQ-033 halted_i=0, read addr 3 -> no strobes; resp_v_o at N+1, err=1, data 0.
REQ-034 Read accepted, halted_i drops at N+1, resp_ready_i held 0 for 4 cycles -> read completes; response held stable; req_ready_o stays 0 until one cycle after the handshake.
REQ-035 reset_n_i pulsed low in CAPTURE -> all outputs 0 immediately; no response after release; req_ready_o=1 the next clock.
REQ-036 Macro defined, halted, write addr 0 data 0x1 -> no irf_w_v_o; err=1 at N+1. Macro undefined -> irf_w_v_o at N+1, err=0.
